write_back_pipe: RTL and testbench

Parametrised write-back stage: the last pipeline stage between the data-memory/ALU result mux and the register file. It selects the ALU or memory result and holds it in a two-entry elastic buffer (head plus skid), so upstream sees a registered ready. It drives the register-file write port, answers forwarding lookups from the hazard unit, keeps the last written value on `ans_wb`, and counts retired instructions. It replaces the fixed 8-bit, stall-less write-back register.

---
 rtl/write_back_pipe.sv | 172 +++++++++++++++++
 tb/tb_write_back_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_pipe.sv
// Write-back stage: ALU/memory result select, two-entry elastic buffer (head + skid)
// feeding the register-file write port, with forwarding lookup, last-write capture and retire count.
module write_back_pipe #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [DATA_W-1:0]     in_mem_res,
  input  logic                  in_sel_mem,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  input  logic                  flush,
  input  logic                  rf_busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic [REG_ADDR_W-1:0] fwd_qaddr,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [DATA_W-1:0]     ans_wb,
  output logic [CNT_W-1:0]      retire_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  function automatic logic [DATA_W-1:0] sel_result(input logic                sel_mem,
                                                   input logic [DATA_W-1:0] alu_res,
                                                   input logic [DATA_W-1:0] mem_res);
    return sel_mem ? mem_res : alu_res;
  endfunction

  // An entry only reaches the register file if it writes and does not target a hard-wired r0.
  function automatic logic writes_reg(input logic we, input logic [REG_ADDR_W-1:0] rd);
    return we && !(ZERO_REG && (rd == '0));
  endfunction

  state_t                state;
  logic                  vld_p1;
  logic                  skid_vld_p1;
  logic                  accept;
  logic                  retire;

  // Stage p0: incoming entry, already muxed
  logic [DATA_W-1:0]     data_p0;

  // Stage p1: head (oldest) and skid (youngest) entries
  logic [DATA_W-1:0]     head_data_p1;
  logic [REG_ADDR_W-1:0] head_rd_p1;
  logic                  head_we_p1;
  logic [DATA_W-1:0]     skid_data_p1;
  logic [REG_ADDR_W-1:0] skid_rd_p1;
  logic                  skid_we_p1;

  logic                  q_ok;
  logic                  head_match;
  logic                  skid_match;

  assign data_p0     = sel_result(in_sel_mem, in_alu_res, in_mem_res);
  assign vld_p1      = (state != EMPTY);
  assign skid_vld_p1 = (state == SKID);
  assign accept      = in_valid & in_ready & ~flush;
  assign retire      = vld_p1 & ~rf_busy & ~flush;

  assign rf_we    = retire & writes_reg(head_we_p1, head_rd_p1);
  assign rf_waddr = head_rd_p1;
  assign rf_wdata = head_data_p1;

  // in_ready is written alongside each state change so it always mirrors "next state != SKID".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      in_ready     <= 1'b1;
      head_data_p1 <= '0;
      head_rd_p1   <= '0;
      head_we_p1   <= 1'b0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state        <= FULL;
            head_data_p1 <= data_p0;
            head_rd_p1   <= in_rd;
            head_we_p1   <= in_we;
          end
        end
        FULL: begin
          if (accept && retire) begin
            head_data_p1 <= data_p0;
            head_rd_p1   <= in_rd;
            head_we_p1   <= in_we;
          end else if (accept) begin
            state    <= SKID;
            in_ready <= 1'b0;
          end else if (retire) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          if (retire) begin
            state        <= FULL;
            in_ready     <= 1'b1;
            head_data_p1 <= skid_data_p1;
            head_rd_p1   <= skid_rd_p1;
            head_we_p1   <= skid_we_p1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Skid contents are only observed while state is SKID, so they need no reset.
  always_ff @(posedge clk) begin
    if ((state == FULL) && accept && !retire) begin
      skid_data_p1 <= data_p0;
      skid_rd_p1   <= in_rd;
      skid_we_p1   <= in_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_wb     <= '0;
      retire_cnt <= '0;
    end else begin
      if (rf_we) begin
        ans_wb <= head_data_p1;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_ONE;
      end
    end
  end

  assign q_ok       = !(ZERO_REG && (fwd_qaddr == '0));
  assign head_match = vld_p1 & head_we_p1 & (head_rd_p1 == fwd_qaddr) & q_ok;
  assign skid_match = skid_vld_p1 & skid_we_p1 & (skid_rd_p1 == fwd_qaddr) & q_ok;

  // Skid is younger than head, so it wins when both match.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!flush) begin
      if (skid_match) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_data_p1;
      end else if (head_match) begin
        fwd_hit  = 1'b1;
        fwd_data = head_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_write_back_pipe.sv
// Randomized scoreboard bench for write_back_pipe with a queue-based reference model.
module tb_write_back_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_alu_res;
  logic [7:0] in_mem_res;
  logic       in_sel_mem;
  logic [2:0] in_rd;
  logic       in_we;
  logic       flush;
  logic       rf_busy;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] fwd_qaddr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
  logic [7:0] ans_wb;
  logic [15:0] retire_cnt;

  write_back_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_res (in_alu_res),
    .in_mem_res (in_mem_res),
    .in_sel_mem (in_sel_mem),
    .in_rd      (in_rd),
    .in_we      (in_we),
    .flush      (flush),
    .rf_busy    (rf_busy),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .fwd_qaddr  (fwd_qaddr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .ans_wb     (ans_wb),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  d;
    logic [2:0]  rd;
    logic        we;
    logic [31:0] gen;
  } ent_t;

  // Reference model state: held entries in age order, expected writes, architectural results.
  ent_t        held[$];
  ent_t        sb[$];
  logic [31:0] gen = 0;
  logic [15:0] m_cnt = 0;
  logic [7:0]  m_ans = 0;
  logic        m_ready = 1'b1;
  logic        last_acc = 1'b0;
  logic        last_fl = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  initial begin
    ent_t e;
    logic acc;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        held.delete();
        gen      = gen + 1;
        m_cnt    = 0;
        m_ans    = 0;
        m_ready  = 1'b1;
        last_acc = 1'b0;
        last_fl  = 1'b0;
      end else begin
        acc = in_valid && m_ready && !flush;
        if (flush) begin
          held.delete();
          gen = gen + 1;
        end else begin
          if (held.size() > 0 && !rf_busy) begin
            e = held.pop_front();
            m_cnt = m_cnt + 16'd1;
            if (e.we && e.rd != 3'd0) m_ans = e.d;
          end
          if (acc) begin
            e.d   = in_sel_mem ? in_mem_res : in_alu_res;
            e.rd  = in_rd;
            e.we  = in_we;
            e.gen = gen;
            held.push_back(e);
            if (e.we && e.rd != 3'd0) sb.push_back(e);
          end
        end
        m_ready  = (held.size() < 2);
        last_acc = acc;
        last_fl  = flush;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the model and the write scoreboard.
  initial begin
    ent_t e;
    logic exp_we;
    logic exp_hit;
    logic [7:0] exp_fd;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd_data", 32'(fwd_data), 32'd0);
        chk("rst_ans_wb", 32'(ans_wb), 32'd0);
        chk("rst_retire_cnt", 32'(retire_cnt), 32'd0);
      end else begin
        exp_we = (held.size() > 0) && !rf_busy && !flush && held[0].we && (held[0].rd != 3'd0);
        chk("rf_we", 32'(rf_we), 32'(exp_we));
        if (rf_we) begin
          while (sb.size() > 0 && sb[0].gen != gen) void'(sb.pop_front());
          if (sb.size() == 0) begin
            chk("unexpected_write_addr", 32'(rf_waddr), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("rf_waddr", 32'(rf_waddr), 32'(e.rd));
            chk("rf_wdata", 32'(rf_wdata), 32'(e.d));
          end
        end
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
        chk("ans_wb", 32'(ans_wb), 32'(m_ans));
        exp_hit = 1'b0;
        exp_fd  = 8'h00;
        if (!flush && fwd_qaddr != 3'd0) begin
          for (int i = held.size() - 1; i >= 0; i--) begin
            if (!exp_hit && held[i].we && held[i].rd == fwd_qaddr) begin
              exp_hit = 1'b1;
              exp_fd  = held[i].d;
            end
          end
        end
        chk("fwd_hit", 32'(fwd_hit), 32'(exp_hit));
        chk("fwd_data", 32'(fwd_data), 32'(exp_fd));
      end
    end
  end

  // One cycle of stimulus; an entry stalled by in_ready=0 is held unchanged.
  task automatic cyc(input logic v, input logic [7:0] alu, input logic [7:0] mem,
                     input logic sel, input logic [2:0] rd, input logic we,
                     input logic fl, input logic busy, input logic [2:0] q);
    if (!(in_valid && !last_acc && !last_fl)) begin
      in_valid   = v;
      in_alu_res = alu;
      in_mem_res = mem;
      in_sel_mem = sel;
      in_rd      = rd;
      in_we      = we;
    end
    flush     = fl;
    rf_busy   = busy;
    fwd_qaddr = q;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
          $urandom_range(0, 5) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          3'($urandom));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_alu_res = 8'h00; in_mem_res = 8'h00; in_sel_mem = 1'b0;
    in_rd = 3'd0; in_we = 1'b0; flush = 1'b0; rf_busy = 1'b0; fwd_qaddr = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single write to r3 from the ALU
    cyc(1'b1, 8'h5A, 8'h00, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3);
    idle(3);

    // Four back-to-back entries alternating ALU / memory
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'h10 + 8'(i), 8'hC3, 1'(i % 2), 3'(i + 1), 1'b1, 1'b0, 1'b0, 3'(i + 1));
    idle(3);

    // Register file busy for 3 cycles while streaming
    for (int i = 0; i < 9; i++)
      cyc(i < 6, 8'h30 + 8'(i), 8'hA0 + 8'(i), 1'(i % 3 == 0), 3'(i % 7 + 1), 1'b1, 1'b0, i < 3, 3'(i % 7 + 1));
    idle(4);

    // Fill SKID with two writes to r2, then query r2 and r5
    cyc(1'b1, 8'h11, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 3'd2);
    cyc(1'b1, 8'h22, 8'h00, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1, 3'd2);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5);

    // Flush while in SKID with a new entry offered
    cyc(1'b1, 8'h77, 8'h00, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2);
    idle(3);

    // Write to r0 is suppressed but retires
    cyc(1'b1, 8'h99, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    idle(3);

    rand_cycles(400);

    // Reset in the middle of a stalled stream
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'h40 + 8'(i), 8'h00, 1'b0, 3'(i + 1), 1'b1, 1'b0, 1'b1, 3'd2);
    in_valid = 1'b0; flush = 1'b0; rf_busy = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    rand_cycles(300);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
